seg7_scan_decoder: RTL and testbench

- Receiving end of the hex-to-seven-segment encoding used by the display path.
- Samples a multiplexed, scanned display bus (active-low digit enables plus active-low segment lines) and recovers the per-digit hex nibbles, with blank and valid flags.
- Used as an in-design monitor and as a self-check for keyboard and display logic.
- Applies a stability filter so that scan transitions and ghosting never commit garbage.

---
 rtl/seg7_scan_decoder.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Monitors a scanned, active-low seven-segment bus and recovers per-digit hex nibbles.
// A commit fires once per window of STABLE identical consecutive samples.
module seg7_scan_decoder #(
   parameter int DIGITS = 8,
   parameter int STABLE = 4
) (
   input  logic                  clk,
   input  logic                  clrn,
   input  logic [DIGITS-1:0]     an_n,
   input  logic [6:0]            seg,
   input  logic                  clr_err,
   output logic [4*DIGITS-1:0]   hex,
   output logic [DIGITS-1:0]     valid,
   output logic [DIGITS-1:0]     blank,
   output logic                  err,
   output logic                  upd,
   output logic [3:0]            upd_idx
);

   localparam int SW = DIGITS + 7;
   localparam int CW = $clog2(STABLE);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

   logic [SW-1:0]       pins;
   logic [SW-1:0]       samp;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_nxt;
   logic                lock;
   logic                lock_nxt;
   logic                same;
   logic                commit;
   logic [DIGITS-1:0]   an_low;
   logic                multi;
   logic [4:0]          dec;
   logic [4*DIGITS-1:0] hex_nxt;
   logic [DIGITS-1:0]   valid_nxt;
   logic [DIGITS-1:0]   blank_nxt;
   logic                err_nxt;
   logic                bad;
   logic [3:0]          idx_sel;
   logic                upd_nxt;
   logic [3:0]          upd_idx_nxt;

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40:   return {1'b1, 4'h0};
         7'h79:   return {1'b1, 4'h1};
         7'h24:   return {1'b1, 4'h2};
         7'h30:   return {1'b1, 4'h3};
         7'h19:   return {1'b1, 4'h4};
         7'h12:   return {1'b1, 4'h5};
         7'h02:   return {1'b1, 4'h6};
         7'h78:   return {1'b1, 4'h7};
         7'h00:   return {1'b1, 4'h8};
         7'h10:   return {1'b1, 4'h9};
         7'h08:   return {1'b1, 4'hA};
         7'h03:   return {1'b1, 4'hB};
         7'h46:   return {1'b1, 4'hC};
         7'h21:   return {1'b1, 4'hD};
         7'h06:   return {1'b1, 4'hE};
         7'h0E:   return {1'b1, 4'hF};
         default: return 5'b0;
      endcase
   endfunction

   assign pins = {an_n, seg};
   assign same = (pins == samp);

   // Commit on the edge where the count reaches its terminal value, so the
   // result appears right after the STABLE-th identical sample.
   always_comb begin
      cnt_nxt = '0;
      if (same) begin
         cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      end
      commit   = same && (cnt_nxt == CNT_MAX) && !lock;
      lock_nxt = same && (lock || commit);
   end

   always_comb begin
      hex_nxt   = hex;
      valid_nxt = valid;
      blank_nxt = blank;
      idx_sel   = upd_idx;
      bad       = 1'b0;
      an_low    = ~an_n;
      multi     = (an_low & (an_low - 1'b1)) != '0;
      dec       = decode(seg);
      if (commit) begin
         if (multi) begin
            bad = 1'b1;
         end else begin
            for (int i = 0; i < DIGITS; i++) begin
               if (an_low[i]) begin
                  idx_sel = 4'(i);
                  if (seg == 7'h7F) begin
                     blank_nxt[i] = 1'b1;
                     valid_nxt[i] = 1'b0;
                  end else if (dec[4]) begin
                     hex_nxt[4*i +: 4] = dec[3:0];
                     valid_nxt[i]      = 1'b1;
                     blank_nxt[i]      = 1'b0;
                  end else begin
                     bad          = 1'b1;
                     valid_nxt[i] = 1'b0;
                     blank_nxt[i] = 1'b0;
                  end
               end
            end
         end
      end
      err_nxt     = bad ? 1'b1 : (clr_err ? 1'b0 : err);
      upd_nxt     = commit && ((hex_nxt != hex) || (valid_nxt != valid) || (blank_nxt != blank));
      upd_idx_nxt = upd_nxt ? idx_sel : upd_idx;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         samp    <= '1;
         cnt     <= '0;
         lock    <= 1'b0;
         hex     <= '0;
         valid   <= '0;
         blank   <= '1;
         err     <= 1'b0;
         upd     <= 1'b0;
         upd_idx <= 4'd0;
      end else begin
         samp    <= pins;
         cnt     <= cnt_nxt;
         lock    <= lock_nxt;
         hex     <= hex_nxt;
         valid   <= valid_nxt;
         blank   <= blank_nxt;
         err     <= err_nxt;
         upd     <= upd_nxt;
         upd_idx <= upd_idx_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized bench for seg7_scan_decoder against a run-length
// reference model of the scanned-bus decoding rules.
module tb_seg7_scan_decoder;

   localparam int DIGITS = 8;
   localparam int STABLE = 4;

   logic        clk;
   logic        clrn;
   logic [7:0]  an_n;
   logic [6:0]  seg;
   logic        clr_err;
   logic [31:0] hex;
   logic [7:0]  valid;
   logic [7:0]  blank;
   logic        err;
   logic        upd;
   logic [3:0]  upd_idx;

   seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
      .clk     (clk),
      .clrn    (clrn),
      .an_n    (an_n),
      .seg     (seg),
      .clr_err (clr_err),
      .hex     (hex),
      .valid   (valid),
      .blank   (blank),
      .err     (err),
      .upd     (upd),
      .upd_idx (upd_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int tests = 0;
   int fails = 0;
   int upd_seen = 0;

   // reference model: a commit happens when the current run of identical
   // samples reaches exactly STABLE edges long
   logic [3:0]  m_hex [8];
   logic        m_valid [8];
   logic        m_blank [8];
   logic        m_err;
   logic        m_upd;
   logic [3:0]  m_idx;
   logic [14:0] m_prev;
   int          m_run;

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m_hex[k]   = 4'h0;
         m_valid[k] = 1'b0;
         m_blank[k] = 1'b1;
      end
      m_err  = 1'b0;
      m_upd  = 1'b0;
      m_idx  = 4'd0;
      m_prev = '1;
      m_run  = 1;
   endtask

   task automatic model_edge(input logic [7:0] a, input logic [6:0] s, input logic c);
      logic [14:0] p;
      logic        bad;
      int          nlow;
      int          d;
      int          nib;
      logic [3:0]  nh;
      logic        nv;
      logic        nb;
      p = {a, s};
      if (p == m_prev) m_run++;
      else begin
         m_run  = 1;
         m_prev = p;
      end
      m_upd = 1'b0;
      bad   = 1'b0;
      if (m_run == STABLE) begin
         nlow = 0;
         d    = 0;
         for (int k = 0; k < 8; k++) if (!a[k]) begin
            nlow++;
            d = k;
         end
         if (nlow > 1) bad = 1'b1;
         else if (nlow == 1) begin
            nib = -1;
            for (int k = 0; k < 16; k++) if (seg_tab[k] == s) nib = k;
            nh = m_hex[d];
            nv = m_valid[d];
            nb = m_blank[d];
            if (s == 7'h7F) begin
               nb = 1'b1;
               nv = 1'b0;
            end else if (nib >= 0) begin
               nh = 4'(nib);
               nv = 1'b1;
               nb = 1'b0;
            end else begin
               bad = 1'b1;
               nv  = 1'b0;
               nb  = 1'b0;
            end
            if (nh != m_hex[d] || nv != m_valid[d] || nb != m_blank[d]) begin
               m_upd = 1'b1;
               m_idx = 4'(d);
            end
            m_hex[d]   = nh;
            m_valid[d] = nv;
            m_blank[d] = nb;
         end
      end
      if (bad) m_err = 1'b1;
      else if (c) m_err = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [31:0] eh;
      logic [7:0]  ev;
      logic [7:0]  eb;
      for (int k = 0; k < 8; k++) begin
         eh[4*k +: 4] = m_hex[k];
         ev[k]        = m_valid[k];
         eb[k]        = m_blank[k];
      end
      chk("hex", hex, eh);
      chk("valid", {24'd0, valid}, {24'd0, ev});
      chk("blank", {24'd0, blank}, {24'd0, eb});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("upd", {31'd0, upd}, {31'd0, m_upd});
      chk("upd_idx", {28'd0, upd_idx}, {28'd0, m_idx});
   endtask

   task automatic step(input logic [7:0] a, input logic [6:0] s, input logic c);
      an_n    = a;
      seg     = s;
      clr_err = c;
      @(posedge clk);
      model_edge(a, s, c);
      #1;
      check_all();
      if (upd === 1'b1) upd_seen++;
   endtask

   task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
      repeat (n) step(a, s, 1'b0);
   endtask

   task automatic scan_word(input logic [31:0] w);
      logic [7:0] a;
      for (int d = 7; d >= 0; d--) begin
         a = ~(8'b1 << d);
         hold(a, seg_tab[w[4*d +: 4]], 10);
      end
   endtask

   initial begin
      logic [7:0] a;
      logic [6:0] s;
      int         kind;
      int         len;
      int         b0;
      int         b1;

      clrn    = 1'b0;
      an_n    = 8'hFF;
      seg     = 7'h7F;
      clr_err = 1'b0;
      model_reset();
      #12;
      check_all();
      clrn = 1'b1;

      upd_seen = 0;
      scan_word(32'h12345678);
      chk("scan1_hex", hex, 32'h12345678);
      chk("scan1_valid", {24'd0, valid}, 32'hFF);
      chk("scan1_upds", upd_seen, 8);

      upd_seen = 0;
      scan_word(32'h12345678);
      chk("scan2_hex", hex, 32'h12345678);
      chk("scan2_upds", upd_seen, 0);

      // glitching seg must not commit until one value is held for a full window
      upd_seen = 0;
      repeat (3) begin
         hold(8'hFE, 7'h40, 2);
         hold(8'hFE, 7'h79, 2);
      end
      hold(8'hFE, 7'h40, 2);
      chk("glitch_noupd", upd_seen, 0);
      hold(8'hFE, 7'h79, 3);
      chk("glitch_early", {31'd0, upd}, 32'd0);
      step(8'hFE, 7'h79, 1'b0);
      chk("glitch_commit", {31'd0, upd}, 32'd1);
      hold(8'hFE, 7'h79, 4);
      chk("glitch_hex0", {28'd0, hex[3:0]}, 32'd1);
      chk("glitch_upds", upd_seen, 1);

      hold(8'hFB, 7'h08, 5);
      step(8'hFB, 7'h7F, 1'b0);
      step(8'hFB, 7'h7F, 1'b0);
      step(8'hFB, 7'h7F, 1'b0);
      step(8'hFB, 7'h7F, 1'b0);
      chk("blank2_upd_idx", {28'd0, upd_idx}, 32'd2);
      chk("blank2_upd", {31'd0, upd}, 32'd1);
      hold(8'hFB, 7'h7F, 1);
      chk("blank2", {31'd0, blank[2]}, 32'd1);
      chk("valid2", {31'd0, valid[2]}, 32'd0);
      chk("hex2_held", {28'd0, hex[11:8]}, 32'hA);

      hold(8'hDF, 7'h7E, 5);
      chk("illegal_err", {31'd0, err}, 32'd1);
      chk("illegal_valid5", {31'd0, valid[5]}, 32'd0);
      hold(8'hFC, 7'h40, 5);
      chk("multi_err", {31'd0, err}, 32'd1);
      step(8'hFC, 7'h40, 1'b1);
      chk("clr_err", {31'd0, err}, 32'd0);

      // clear and a fresh error commit on the same edge: the error wins
      hold(8'hDF, 7'h7E, 3);
      step(8'hDF, 7'h7E, 1'b1);
      chk("clr_vs_err", {31'd0, err}, 32'd1);
      step(8'hFF, 7'h7F, 1'b1);
      chk("clr_err2", {31'd0, err}, 32'd0);

      hold(8'hFE, 7'h30, 3);
      clrn = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      clrn = 1'b1;
      hold(8'hFE, 7'h30, 3);
      chk("rst_nocommit", {24'd0, valid}, 32'd0);
      step(8'hFE, 7'h30, 1'b0);
      chk("rst_commit", {28'd0, hex[3:0]}, 32'd3);

      for (int r = 0; r < 300; r++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 2) a = 8'hFF;
         else if (kind == 2) begin
            b0 = int'($urandom_range(0, 7));
            b1 = (b0 + int'($urandom_range(1, 7))) % 8;
            a  = ~((8'b1 << b0) | (8'b1 << b1));
         end else a = ~(8'b1 << $urandom_range(0, 7));
         kind = int'($urandom_range(0, 19));
         if (kind < 14) s = seg_tab[$urandom_range(0, 15)];
         else if (kind < 17) s = 7'h7F;
         else s = 7'($urandom);
         len = int'($urandom_range(1, 7));
         repeat (len) step(a, s, ($urandom_range(0, 9) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
